fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch sequencer for the 8-bit CPU, sitting between the program counter and the instruction memory port. It reads the current PC value, issues memory reads with a req/ack handshake, and assembles one- or two-byte instructions into an instruction register. It offers that register to the decoder over valid/ready. It is the sole driver of the PC's enable/inc/in control inputs, for both sequential advance and jump loads.

## Interface
- DATA_WIDTH, 8, width of PC, memory data and instruction fields (from param.v)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- pc_addr  in  DATA_WIDTH  current PC value
- pc_enable  out  1  PC update strobe
- pc_inc  out  1  with pc_enable: 1 = increment, 0 = load pc_in
- pc_in  out  DATA_WIDTH  PC load value (jump target)
- mem_req  out  1  read request; held until acked
- mem_addr  out  DATA_WIDTH  read address
- mem_ack  in  1  read complete; mem_data valid this cycle
- mem_data  in  DATA_WIDTH  read data
- ir_valid  out  1  instruction available
- ir_opcode  out  DATA_WIDTH  opcode byte
- ir_operand  out  DATA_WIDTH  operand byte (0 for one-byte instructions)
- ir_ready  in  1  decoder accepts instruction
- jump_req  in  1  single-cycle pulse: redirect fetch
- jump_target  in  DATA_WIDTH  jump destination, valid with jump_req
- halt  in  1  level: suppress new opcode fetches

## Operation
- States: S_OP (fetch opcode), S_ARG (fetch operand), S_OUT (present instruction).
- On reset: state S_OP, ir_valid=0, ir_opcode=0, ir_operand=0, jump_pend=0. While reset is high, mem_req=0 and pc_enable=0.
- mem_addr = pc_addr at all times.
- mem_req = 1 in S_OP when halt=0, and in S_ARG. mem_req = 0 in S_OUT. A request in S_ARG is never withdrawn because of halt.
- Once mem_req is 1, it stays high until mem_ack. mem_ack with mem_req=0 is ignored.
- On an ack cycle, pc_enable=1:
  - No pending jump: pc_inc=1.
  - jump_pend=1: pc_inc=0, pc_in=jump_tgt, the fetched byte is discarded, jump_pend clears, and the next state is S_OP.
- S_OP ack: latch ir_opcode=mem_data.
  - mem_data[7]=1: next state S_ARG.
  - mem_data[7]=0: ir_operand=0, ir_valid=1, next state S_OUT.
- S_ARG ack: latch ir_operand=mem_data, set ir_valid=1, next state S_OUT.
- S_OUT: hold the IR stable. When ir_valid && ir_ready, clear ir_valid and go to S_OP.
- jump_req handling:
  - In S_OUT, or in S_OP with mem_req=0 (halted): same cycle pc_enable=1, pc_inc=0, pc_in=jump_target. ir_valid clears and the next state is S_OP. This takes priority over an ir_ready handshake in the same cycle: the instruction is not consumed and is not re-presented.
  - In S_OP/S_ARG with mem_req=1 and no ack this cycle: store jump_tgt=jump_target and set jump_pend=1. A later jump_req before the ack overwrites jump_tgt.
  - In S_OP/S_ARG coinciding with mem_ack: the jump wins. Load jump_target directly (no increment), discard the byte, next state S_OP.
- pc_enable=0 in every cycle not listed above.
- PC wrap (0xFF → 0x00) is the PC's responsibility. The fetch unit continues fetching from 0x00 without special handling.

## Timing
- mem_req, mem_addr, pc_enable, pc_inc and pc_in are combinational from state, registers and inputs. ir_* outputs are registered.
- Zero-wait memory (ack in the same cycle as req):
  - One-byte instruction: ir_valid rises 1 clock after the opcode request.
  - Two-byte instruction: ir_valid rises 2 clocks after the opcode request.
  - Next opcode request: the cycle after the ir handshake.
- Each memory wait state adds 1 cycle per byte.
- Sustained throughput with ir_ready held high and zero-wait memory: one-byte instruction every 2 cycles, two-byte every 3.
- The PC changes at most once per clock, and only on cycles where pc_enable=1.
- Reset asserted mid-fetch: the request drops that cycle. An ack arriving during reset is ignored and causes no PC update.

## Test plan
- Zero-wait memory, PC=0x10, mem holds 0x05 → mem_req at 0x10, pc_enable&pc_inc for 1 cycle, ir_valid next cycle with opcode 0x05 / operand 0x00; PC=0x11.
- Mem holds 0x83,0x42 at 0x20/0x21, ack delayed 2 cycles per byte → opcode 0x83, operand 0x42, ir_valid 6 cycles after the first request; PC=0x22; exactly two increments.
- ir_valid held with ir_ready=0 for 5 cycles → IR stable, mem_req=0, pc_enable=0. ir_ready=1 → ir_valid drops and the next request issues the following cycle.
- jump_req (target 0x80) during a pending opcode request, ack 3 cycles later → no increment; on the ack cycle pc_enable=1, pc_inc=0, pc_in=0x80; the byte is discarded; the next request is at 0x80.
- jump_req to 0x40 in S_OUT in the same cycle as ir_ready → PC loads 0x40, the instruction is dropped, and the fetch at 0x40 starts the next cycle.
- halt=1 in S_OP → no mem_req, PC frozen. Then jump_req to 0x33 → PC=0x33 while still halted. halt=0 → fetch at 0x33. Separately: reset pulse mid-S_ARG → all ir_* outputs 0 and fetch restarts in S_OP.

Source files
------------

// File: rtl/fetch_if.sv
// fetch_if: PC control, instruction memory and decoder-side signals of the fetch unit.
interface fetch_if #(parameter int DATA_WIDTH = 8);
  logic [DATA_WIDTH-1:0] pc_addr, pc_in, mem_addr, mem_data, ir_opcode, ir_operand, jump_target;
  logic pc_enable, pc_inc, mem_req, mem_ack, ir_valid, ir_ready, jump_req, halt;
  modport master (
    input  pc_addr, mem_ack, mem_data, ir_ready, jump_req, jump_target, halt,
    output pc_enable, pc_inc, pc_in, mem_req, mem_addr, ir_valid, ir_opcode, ir_operand
  );
  modport slave (
    output pc_addr, mem_ack, mem_data, ir_ready, jump_req, jump_target, halt,
    input  pc_enable, pc_inc, pc_in, mem_req, mem_addr, ir_valid, ir_opcode, ir_operand
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: fetches one- or two-byte instructions at the PC, drives PC advance/jump
// loads, and presents the assembled instruction to the decoder over valid/ready.
module fetch_unit #(parameter int DATA_WIDTH = 8) (
  input logic clk,
  input logic reset,
  fetch_if.master f
);
  typedef enum logic [1:0] {S_OP, S_ARG, S_OUT} state_t;
  state_t state;
  logic jump_pend, req_pend, ack, jmp_now, redirect;
  logic [DATA_WIDTH-1:0] jump_tgt;
  // req_pend keeps an issued opcode request alive if halt rises before the ack
  assign f.mem_addr = f.pc_addr;
  assign f.mem_req = !reset && (state == S_ARG || (state == S_OP && (!f.halt || req_pend)));
  assign ack = f.mem_req && f.mem_ack;
  assign jmp_now = !reset && f.jump_req && !f.mem_req;
  assign redirect = ack && (jump_pend || f.jump_req);
  assign f.pc_enable = ack || jmp_now;
  assign f.pc_inc = ack && !redirect;
  assign f.pc_in = f.jump_req ? f.jump_target : jump_tgt;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_OP;
      f.ir_valid <= 1'b0;
      f.ir_opcode <= '0;
      f.ir_operand <= '0;
      jump_pend <= 1'b0;
      jump_tgt <= '0;
      req_pend <= 1'b0;
    end else begin
      req_pend <= f.mem_req && !f.mem_ack;
      if (jmp_now) begin
        state <= S_OP;
        f.ir_valid <= 1'b0;
      end else if (redirect) begin
        state <= S_OP;
        jump_pend <= 1'b0;
      end else if (f.mem_req && f.jump_req) begin
        jump_pend <= 1'b1;
        jump_tgt <= f.jump_target;
      end else if (ack && state == S_OP) begin
        f.ir_opcode <= f.mem_data;
        state <= f.mem_data[DATA_WIDTH-1] ? S_ARG : S_OUT;
        f.ir_valid <= !f.mem_data[DATA_WIDTH-1];
        if (!f.mem_data[DATA_WIDTH-1]) f.ir_operand <= '0;
      end else if (ack) begin
        f.ir_operand <= f.mem_data;
        f.ir_valid <= 1'b1;
        state <= S_OUT;
      end else if (state == S_OUT && f.ir_valid && f.ir_ready) begin
        f.ir_valid <= 1'b0;
        state <= S_OP;
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a PC/memory model; presented instructions are
// checked against a queue of expected {opcode, operand} pairs.
module tb_fetch_unit;
  logic clk = 0;
  logic reset = 1;
  always #5 clk = ~clk;
  fetch_if #(8) bus ();
  fetch_unit #(.DATA_WIDTH(8)) dut (.clk(clk), .reset(reset), .f(bus));
  int tests = 0;
  int fails = 0;
  logic [7:0] mem [256];
  logic [7:0] pc, pc_set_val;
  logic pc_set = 0;
  logic force_ack = 0;
  int wait_n = 0;
  int cnt = 0;
  int incs = 0;
  logic [15:0] expq [$];
  logic prev_v = 0;
  assign bus.pc_addr = pc;
  assign bus.mem_data = mem[bus.mem_addr];
  assign bus.mem_ack = force_ack | (bus.mem_req && cnt >= wait_n);
  always @(posedge clk) begin
    cnt <= (bus.mem_req && !bus.mem_ack) ? cnt + 1 : 0;
    if (pc_set) begin
      pc <= pc_set_val;
      incs <= 0;
    end else if (bus.pc_enable) begin
      pc <= bus.pc_inc ? pc + 8'd1 : bus.pc_in;
      if (bus.pc_inc) incs <= incs + 1;
    end
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (bus.ir_valid && !prev_v) begin
      if (expq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL ir_unexpected: got %0h expected none", {bus.ir_opcode, bus.ir_operand});
      end else check("ir", {bus.ir_opcode, bus.ir_operand}, expq.pop_front());
    end
    prev_v = bus.ir_valid;
  end
  task automatic restart(input logic [7:0] p, input int w);
    reset = 1;
    force_ack = 1;
    bus.jump_req = 0;
    bus.ir_ready = 0;
    wait_n = w;
    pc_set = 1;
    pc_set_val = p;
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", bus.ir_valid, 0);
    check("rst_opcode", bus.ir_opcode, 0);
    check("rst_operand", bus.ir_operand, 0);
    check("rst_req", bus.mem_req, 0);
    check("rst_pc_en", bus.pc_enable, 0);
    pc_set = 0;
    force_ack = 0;
    reset = 0;
  endtask
  initial begin
    logic [5:0] pat;
    int k;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    bus.halt = 0;
    bus.jump_req = 0;
    bus.jump_target = 0;
    bus.ir_ready = 0;
    // one-byte, zero-wait, then back-pressure hold
    mem[8'h10] = 8'h05;
    expq.push_back(16'h0500);
    restart(8'h10, 0);
    #1;
    check("t1_req", bus.mem_req, 1);
    check("t1_addr", bus.mem_addr, 8'h10);
    check("t1_pc_en", bus.pc_enable, 1);
    check("t1_pc_inc", bus.pc_inc, 1);
    @(negedge clk);
    check("t1_pc", pc, 8'h11);
    check("t1_valid", bus.ir_valid, 1);
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", bus.ir_valid, 1);
      check("hold_opcode", bus.ir_opcode, 8'h05);
      check("hold_req", bus.mem_req, 0);
      check("hold_pc_en", bus.pc_enable, 0);
      @(negedge clk);
    end
    wait_n = 1000;
    bus.ir_ready = 1;
    #1;
    check("hs_pc_en", bus.pc_enable, 0);
    @(negedge clk);
    bus.ir_ready = 0;
    check("hs_valid", bus.ir_valid, 0);
    #1;
    check("hs_next_req", bus.mem_req, 1);
    check("hs_next_addr", bus.mem_addr, 8'h11);
    // two-byte with two wait states per byte
    mem[8'h20] = 8'h83;
    mem[8'h21] = 8'h42;
    expq.push_back(16'h8342);
    restart(8'h20, 2);
    k = 0;
    for (int i = 1; i <= 20 && k == 0; i++) begin
      @(negedge clk);
      if (bus.ir_valid) k = i;
    end
    check("t2_latency", k, 6);
    check("t2_pc", pc, 8'h22);
    check("t2_incs", incs, 2);
    // jump while opcode request waits, ack 3 cycles later
    mem[8'h30] = 8'h01;
    mem[8'h80] = 8'h07;
    restart(8'h30, 3);
    @(negedge clk);
    bus.jump_req = 1;
    bus.jump_target = 8'h80;
    #1;
    check("t4_pend_pc_en", bus.pc_enable, 0);
    check("t4_pend_req", bus.mem_req, 1);
    @(negedge clk);
    bus.jump_req = 0;
    bus.jump_target = 8'h00;
    #1;
    check("t4_wait_pc_en", bus.pc_enable, 0);
    @(negedge clk);
    #1;
    check("t4_ack_pc_en", bus.pc_enable, 1);
    check("t4_ack_pc_inc", bus.pc_inc, 0);
    check("t4_ack_pc_in", bus.pc_in, 8'h80);
    expq.push_back(16'h0700);
    wait_n = 0;
    @(negedge clk);
    check("t4_pc", pc, 8'h80);
    check("t4_incs", incs, 0);
    check("t4_addr", bus.mem_addr, 8'h80);
    check("t4_req", bus.mem_req, 1);
    @(negedge clk);
    check("t4_pc_after", pc, 8'h81);
    // jump in S_OUT coinciding with ir_ready
    mem[8'h50] = 8'h09;
    mem[8'h40] = 8'h0A;
    expq.push_back(16'h0900);
    restart(8'h50, 0);
    @(negedge clk);
    bus.ir_ready = 1;
    bus.jump_req = 1;
    bus.jump_target = 8'h40;
    expq.push_back(16'h0A00);
    #1;
    check("t5_pc_en", bus.pc_enable, 1);
    check("t5_pc_inc", bus.pc_inc, 0);
    check("t5_pc_in", bus.pc_in, 8'h40);
    @(negedge clk);
    bus.jump_req = 0;
    bus.ir_ready = 0;
    check("t5_pc", pc, 8'h40);
    check("t5_valid", bus.ir_valid, 0);
    #1;
    check("t5_req", bus.mem_req, 1);
    check("t5_addr", bus.mem_addr, 8'h40);
    @(negedge clk);
    check("t5_valid_new", bus.ir_valid, 1);
    check("t5_pc_new", pc, 8'h41);
    // halt, jump while halted, resume
    bus.halt = 1;
    restart(8'h60, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t6_halt_req", bus.mem_req, 0);
      check("t6_halt_pc_en", bus.pc_enable, 0);
      check("t6_halt_pc", pc, 8'h60);
      @(negedge clk);
    end
    bus.jump_req = 1;
    bus.jump_target = 8'h33;
    #1;
    check("t6_jmp_pc_en", bus.pc_enable, 1);
    check("t6_jmp_pc_inc", bus.pc_inc, 0);
    check("t6_jmp_pc_in", bus.pc_in, 8'h33);
    @(negedge clk);
    bus.jump_req = 0;
    check("t6_pc", pc, 8'h33);
    #1;
    check("t6_still_halted", bus.mem_req, 0);
    mem[8'h33] = 8'h11;
    expq.push_back(16'h1100);
    bus.halt = 0;
    #1;
    check("t6_resume_req", bus.mem_req, 1);
    check("t6_resume_addr", bus.mem_addr, 8'h33);
    @(negedge clk);
    check("t6_valid", bus.ir_valid, 1);
    check("t6_pc_after", pc, 8'h34);
    // reset pulse while waiting for the operand
    mem[8'h70] = 8'h85;
    mem[8'h71] = 8'h02;
    restart(8'h70, 2);
    repeat (3) @(negedge clk);
    check("t7_opcode", bus.ir_opcode, 8'h85);
    check("t7_arg_req", bus.mem_req, 1);
    check("t7_valid", bus.ir_valid, 0);
    check("t7_pc", pc, 8'h71);
    reset = 1;
    force_ack = 1;
    #1;
    check("t7_rst_req", bus.mem_req, 0);
    check("t7_rst_pc_en", bus.pc_enable, 0);
    expq.push_back(16'h0200);
    @(negedge clk);
    check("t7_rst_valid", bus.ir_valid, 0);
    check("t7_rst_opcode", bus.ir_opcode, 0);
    check("t7_rst_operand", bus.ir_operand, 0);
    check("t7_rst_pc", pc, 8'h71);
    reset = 0;
    force_ack = 0;
    wait_n = 0;
    #1;
    check("t7_restart_req", bus.mem_req, 1);
    check("t7_restart_addr", bus.mem_addr, 8'h71);
    @(negedge clk);
    check("t7_pc_after", pc, 8'h72);
    // sustained throughput with ir_ready high
    mem[8'h90] = 8'h01;
    mem[8'h91] = 8'h81;
    mem[8'h92] = 8'h22;
    mem[8'h93] = 8'h03;
    expq.push_back(16'h0100);
    expq.push_back(16'h8122);
    expq.push_back(16'h0300);
    restart(8'h90, 0);
    bus.ir_ready = 1;
    pat = 6'b101001;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("thru_valid", bus.ir_valid, pat[i]);
    end
    bus.ir_ready = 0;
    check("thru_pc", pc, 8'h94);
    @(negedge clk);
    check("queue_empty", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
